// File: rtl/dpll_pkg.sv
// Shared types for the digital PLL: control-word type and DCO state encoding.
package dpll_pkg;

    localparam int CTRL_W = 16;

    // Signed filtered control word, also produced by the loop filter.
    typedef logic signed [CTRL_W-1:0] ctrl_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } dco_state_t;

endpackage

// File: rtl/dco_fcw_map.sv
// Control-word to frequency-control-word map: gain shift, offset by the
// free-running FCW, then clamp into the legal oscillation range.
module dco_fcw_map
    import dpll_pkg::*;
#(
    parameter int               ACC_W      = 24,
    parameter logic [ACC_W-1:0] BASE_FCW   = 24'h19999A,
    parameter int               GAIN_SHIFT = 4,
    parameter logic [ACC_W-1:0] FCW_MIN    = 24'h000100,
    parameter logic [ACC_W-1:0] FCW_MAX    = 24'h7FFFFF
) (
    input  ctrl_t              i_control,
    output logic [ACC_W-1:0]   o_result,
    output logic               o_clamp
);

    // Wide enough that neither the shift nor the add can overflow.
    localparam int T_W = ACC_W + CTRL_W + 2;
    typedef logic signed [T_W-1:0] wide_t;

    localparam wide_t W_MIN = wide_t'(FCW_MIN);
    localparam wide_t W_MAX = wide_t'(FCW_MAX);

    wide_t w_ctrl_ext;
    wide_t w_t;

    assign w_ctrl_ext = wide_t'(i_control);
    assign w_t        = wide_t'(BASE_FCW) + (w_ctrl_ext <<< GAIN_SHIFT);

    // NOTE: every output gets a default first so no path infers a latch.
    always_comb begin
        o_result = w_t[ACC_W-1:0];
        o_clamp  = 1'b0;
        if (w_t < W_MIN) begin
            o_result = FCW_MIN;
            o_clamp  = 1'b1;
        end else if (w_t > W_MAX) begin
            o_result = FCW_MAX;
            o_clamp  = 1'b1;
        end
    end

endmodule

// File: rtl/dco_nco.sv
// Phase-accumulator DCO: the accumulator MSB is the output clock, and new
// FCWs only take effect at accumulator wrap so frequency steps are glitch-free.
module dco_nco
    import dpll_pkg::*;
#(
    parameter int               ACC_W      = 24,
    parameter logic [ACC_W-1:0] BASE_FCW   = 24'h19999A,
    parameter int               GAIN_SHIFT = 4,
    parameter logic [ACC_W-1:0] FCW_MIN    = 24'h000100,
    parameter logic [ACC_W-1:0] FCW_MAX    = 24'h7FFFFF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  ctrl_t              control,
    input  logic               ctrl_valid,
    output logic               ctrl_ready,
    output logic               dco_clk,
    output logic               dco_tick,
    output logic [ACC_W-1:0]   fcw,
    output logic               sat,
    output logic               running
);

    // An FCW with the MSB set would leave dco_clk without a low phase.
    if (FCW_MIN == '0) begin : g_bad_min
        $error("dco_nco: FCW_MIN must be at least 1");
    end
    if (FCW_MAX[ACC_W-1]) begin : g_bad_max
        $error("dco_nco: FCW_MAX must be below 2^(ACC_W-1)");
    end
    if (FCW_MIN > FCW_MAX) begin : g_bad_range
        $error("dco_nco: FCW_MIN must not exceed FCW_MAX");
    end

    dco_state_t        r_state;
    dco_state_t        w_state_next;
    logic [ACC_W-1:0]  r_acc;
    logic [ACC_W-1:0]  w_acc_next;
    logic [ACC_W-1:0]  r_fcw;
    logic [ACC_W-1:0]  r_pend;
    logic              r_pend_valid;
    logic              r_sat;
    logic              r_dco_clk;
    logic              r_dco_tick;
    logic [ACC_W-1:0]  w_map_fcw;
    logic              w_map_clamp;
    logic [ACC_W:0]    w_sum;
    logic              w_active;
    logic              w_wrap;
    logic              w_accept;
    logic              w_apply;

    dco_fcw_map #(
        .ACC_W      (ACC_W),
        .BASE_FCW   (BASE_FCW),
        .GAIN_SHIFT (GAIN_SHIFT),
        .FCW_MIN    (FCW_MIN),
        .FCW_MAX    (FCW_MAX)
    ) u_fcw_map (
        .i_control (control),
        .o_result  (w_map_fcw),
        .o_clamp   (w_map_clamp)
    );

    assign w_active = (r_state != IDLE);
    assign w_sum    = {1'b0, r_acc} + {1'b0, r_fcw};
    assign w_wrap   = w_active && w_sum[ACC_W];
    assign w_accept = ctrl_valid && !r_pend_valid;
    // Accept and apply are exclusive: accepting requires an empty pending slot.
    assign w_apply  = r_pend_valid && (w_wrap || (r_state == IDLE));

    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        unique case (r_state)
            IDLE: begin
                w_acc_next = '0;
                if (enable) w_state_next = RUN;
            end
            RUN: begin
                w_acc_next = w_sum[ACC_W-1:0];
                if (!enable) w_state_next = STOP;
            end
            STOP: begin
                w_acc_next = w_sum[ACC_W-1:0];
                if (enable) begin
                    w_state_next = RUN;
                end else if (w_wrap) begin
                    w_state_next = IDLE;
                    w_acc_next   = '0;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_acc_next   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_acc      <= '0;
            r_dco_clk  <= 1'b0;
            r_dco_tick <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_acc      <= w_acc_next;
            r_dco_clk  <= w_acc_next[ACC_W-1];
            r_dco_tick <= w_wrap;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fcw        <= BASE_FCW;
            r_pend       <= BASE_FCW;
            r_pend_valid <= 1'b0;
            r_sat        <= 1'b0;
        end else if (w_accept) begin
            r_pend       <= w_map_fcw;
            r_pend_valid <= 1'b1;
            r_sat        <= w_map_clamp;
        end else if (w_apply) begin
            r_fcw        <= r_pend;
            r_pend_valid <= 1'b0;
        end
    end

    assign ctrl_ready = !r_pend_valid;
    assign dco_clk    = r_dco_clk;
    assign dco_tick   = r_dco_tick;
    assign fcw        = r_fcw;
    assign sat        = r_sat;
    assign running    = w_active;

endmodule

// File: tb/tb_dco_nco.sv
// Directed bench for dco_nco with an 8-bit accumulator, BASE_FCW=32,
// GAIN_SHIFT=4 and an FCW range of 1..127.
module tb_dco_nco;
    import dpll_pkg::*;

    localparam int ACC_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable;
    ctrl_t            control;
    logic             ctrl_valid;
    logic             ctrl_ready;
    logic             dco_clk;
    logic             dco_tick;
    logic [ACC_W-1:0] fcw;
    logic             sat;
    logic             running;

    int n_checks = 0;
    int n_errors = 0;
    int cycles;
    int highs;

    dco_nco #(
        .ACC_W      (ACC_W),
        .BASE_FCW   (8'd32),
        .GAIN_SHIFT (4),
        .FCW_MIN    (8'd1),
        .FCW_MAX    (8'd127)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .control    (control),
        .ctrl_valid (ctrl_valid),
        .ctrl_ready (ctrl_ready),
        .dco_clk    (dco_clk),
        .dco_tick   (dco_tick),
        .fcw        (fcw),
        .sat        (sat),
        .running    (running)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(input string tag, input int budget);
        int n = 0;
        step();
        while (!dco_tick && n < budget) begin
            step();
            n++;
        end
        check({tag, " tick"}, dco_tick, 1'b1);
    endtask

    // Cycles until the next tick (inclusive) and how many of them had dco_clk high.
    task automatic measure(input int budget, output int n_cyc, output int n_high);
        n_cyc  = 0;
        n_high = 0;
        do begin
            step();
            n_cyc++;
            if (dco_clk) n_high++;
        end while (!dco_tick && n_cyc < budget);
    endtask

    initial begin
        rst_n      = 1'b1;
        enable     = 1'b0;
        control    = '0;
        ctrl_valid = 1'b0;

        // Asynchronous reset, checked before any clock edge
        #2 rst_n = 1'b0;
        #1;
        check("rst ready",   ctrl_ready, 1'b1);
        check("rst fcw",     fcw,        8'd32);
        check("rst dco_clk", dco_clk,    1'b0);
        check("rst tick",    dco_tick,   1'b0);
        check("rst running", running,    1'b0);
        check("rst sat",     sat,        1'b0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Free-running at BASE_FCW: period 8, 50% duty
        enable = 1'b1;
        wait_tick("base first", 20);
        measure(600, cycles, highs);
        check("base period", cycles, 8);
        check("base high",   highs,  4);
        check("base fcw",    fcw,    8'd32);
        check("base running", running, 1'b1);

        // control=+2 mid-period: FCW 64 only from the next wrap
        step(); step(); step();
        control    = 16'sd2;
        ctrl_valid = 1'b1;
        step();
        ctrl_valid = 1'b0;
        check("p2 ready low", ctrl_ready, 1'b0);
        check("p2 fcw held",  fcw,        8'd32);
        wait_tick("p2 apply", 20);
        check("p2 fcw",       fcw,        8'd64);
        check("p2 ready",     ctrl_ready, 1'b1);
        check("p2 sat",       sat,        1'b0);
        measure(600, cycles, highs);
        check("p2 period", cycles, 4);
        check("p2 high",   highs,  2);

        // Clamp high then low
        control    = 16'sd32767;
        ctrl_valid = 1'b1;
        step();
        ctrl_valid = 1'b0;
        check("max sat",   sat,        1'b1);
        check("max ready", ctrl_ready, 1'b0);
        wait_tick("max apply", 20);
        check("max fcw",   fcw,        8'd127);
        control    = -16'sd32768;
        ctrl_valid = 1'b1;
        step();
        ctrl_valid = 1'b0;
        check("min sat",   sat,        1'b1);
        wait_tick("min apply", 20);
        check("min fcw",   fcw,        8'd1);
        wait_tick("min align", 300);
        measure(600, cycles, highs);
        check("min period", cycles, 256);
        check("min high",   highs,  128);

        // Valid held across two words: second waits for the first to apply
        control    = 16'sd1;
        ctrl_valid = 1'b1;
        step();
        check("hold A ready", ctrl_ready, 1'b0);
        control = -16'sd1;
        wait_tick("hold A apply", 300);
        check("hold A fcw",   fcw,        8'd48);
        check("hold A freed", ctrl_ready, 1'b1);
        step();
        ctrl_valid = 1'b0;
        check("hold B ready", ctrl_ready, 1'b0);
        check("hold B fcw held", fcw,     8'd48);
        wait_tick("hold B apply", 20);
        check("hold B fcw",   fcw,        8'd16);
        check("hold B sat",   sat,        1'b0);
        control    = 16'sd0;
        ctrl_valid = 1'b1;
        step();
        ctrl_valid = 1'b0;
        wait_tick("zero apply", 40);
        check("zero fcw", fcw, 8'd32);
        measure(600, cycles, highs);
        check("zero period", cycles, 8);

        // Graceful stop with enable dropped at acc=0x60
        step(); step(); step();
        enable = 1'b0;
        step();
        check("stop running", running, 1'b1);
        check("stop dco_clk", dco_clk, 1'b1);
        measure(20, cycles, highs);
        check("stop to wrap", cycles, 4);
        check("stop high",    highs,  3);
        check("stop idle",    running, 1'b0);
        check("stop clk low", dco_clk, 1'b0);
        measure(10, cycles, highs);
        check("idle no tick", cycles, 10);
        check("idle no high", highs,  0);

        // In IDLE a pending word applies on the following cycle
        control    = 16'sd2;
        ctrl_valid = 1'b1;
        step();
        ctrl_valid = 1'b0;
        check("idle ready low", ctrl_ready, 1'b0);
        step();
        check("idle fcw",   fcw,        8'd64);
        check("idle ready", ctrl_ready, 1'b1);

        // Run, leave a word pending, then reset asynchronously mid-RUN
        enable     = 1'b1;
        control    = 16'sd32767;
        ctrl_valid = 1'b1;
        step();
        ctrl_valid = 1'b0;
        check("pre sat",     sat,        1'b1);
        check("pre running", running,    1'b1);
        step();
        check("pre fcw", fcw, 8'd64);
        step();
        check("pre dco_clk", dco_clk, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid rst fcw",     fcw,        8'd32);
        check("mid rst sat",     sat,        1'b0);
        check("mid rst ready",   ctrl_ready, 1'b1);
        check("mid rst running", running,    1'b0);
        check("mid rst dco_clk", dco_clk,    1'b0);
        check("mid rst tick",    dco_tick,   1'b0);
        #3 rst_n = 1'b1;
        wait_tick("post rst", 20);
        check("post rst fcw", fcw, 8'd32);
        measure(600, cycles, highs);
        check("post rst period", cycles, 8);
        check("post rst high",   highs,  4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dco_nco.md
Name: dco_nco

Overview:
- Digitally controlled oscillator. It is the block that turns the loop-filter control word back into the PLL output clock, and replaces the FPGA vendor PLL in the ASIC build.
- A phase accumulator runs on a fast system clock. Its frequency control word (FCW) is derived from the signed filtered control value.
- The accumulator MSB is the DCO clock, which feeds the output pin and the N-divider / PFD path.
- Control updates are applied only at accumulator wrap, so frequency changes are phase-continuous and glitch-free.

Parameters:
- ACC_W, 24, accumulator width in bits.
- CTRL_W, 16, width of the signed control input.
- BASE_FCW, 24'h19999A, free-running FCW applied when control = 0.
- GAIN_SHIFT, 4, control is arithmetically left-shifted by this many bits before being added to BASE_FCW.
- FCW_MIN, 24'h000100, lower clamp on FCW (must be ≥ 1).
- FCW_MAX, 24'h7FFFFF, upper clamp on FCW (must be < 2^(ACC_W-1) so dco_clk has a high and low phase every period).

Ports:
- clk, input, 1, fast system clock.
- rst_n, input, 1, asynchronous active-low reset.
- enable, input, 1, run request; deassertion triggers a graceful stop.
- control, input, CTRL_W, signed filtered control word.
- ctrl_valid, input, 1, control is valid this cycle.
- ctrl_ready, output, 1, DCO can accept a control word.
- dco_clk, output, 1, oscillator output (registered accumulator MSB).
- dco_tick, output, 1, one-cycle pulse on each accumulator wrap.
- fcw, output, ACC_W, currently applied FCW.
- sat, output, 1, last accepted control word was clamped.
- running, output, 1, high in RUN and STOP states.

Behaviour:
- Reset (async, rst_n low) sets:
  - acc = 0, fcw = BASE_FCW, pending = none, sat = 0;
  - dco_clk = 0, dco_tick = 0, running = 0, ctrl_ready = 1;
  - state = IDLE.
- FCW map (combinational):
  - t = BASE_FCW + (sign_ext(control) <<< GAIN_SHIFT), computed at ACC_W+CTRL_W+2 signed bits so no intermediate overflow.
  - If t < FCW_MIN, result = FCW_MIN and clamp = 1. If t > FCW_MAX, result = FCW_MAX and clamp = 1. Otherwise result = t and clamp = 0.
- Handshake:
  - ctrl_ready = !pending_valid. A transfer occurs on ctrl_valid && ctrl_ready.
  - The mapped FCW goes into the pending register and sat updates the next cycle.
  - ctrl_valid while ctrl_ready = 0 is ignored; the source must hold it.
  - Transfers are accepted in every state, including IDLE.
- Apply rule:
  - On a wrap cycle with pending_valid, fcw <= pending and pending is cleared.
  - A transfer in the same cycle as a wrap is not bypassed. It is applied at the next wrap.
  - In IDLE a pending value is applied immediately on the next cycle.
- Accumulator:
  - In RUN/STOP: acc <= (acc + fcw) mod 2^ACC_W. wrap = carry-out of that add.
  - dco_clk <= acc_next[ACC_W-1]. dco_tick <= wrap (one cycle, registered).
  - Output frequency = f_clk · fcw / 2^ACC_W.
- States:
  - IDLE: acc held at 0, dco_clk = 0. On enable = 1, go to RUN on the next cycle; accumulation starts in the first RUN cycle.
  - RUN: accumulate. On enable = 0, go to STOP.
  - STOP: keep accumulating until the first wrap, then go to IDLE and clear acc to 0. The final period completes, so dco_clk has no runt pulse.
  - STOP with enable = 1 again: return to RUN with no reset of acc.
- Reset mid-operation: immediate return to reset values. dco_clk may truncate; this is acceptable only under reset.
- Latency:
  - control to pending: 1 cycle.
  - pending to fcw: until the next wrap.
  - acc to dco_clk: 1 register.

Decomposition:
- Package dpll_pkg holds:
  - CTRL_W;
  - typedef ctrl_t (logic signed [CTRL_W-1:0]), shared with the LPF output;
  - enum dco_state_t {IDLE, RUN, STOP}.
- One sub-module, dco_fcw_map: combinational shift, add and clamp, producing result and clamp flag. It is unit-testable on its own.

Test Plan (ACC_W=8, BASE_FCW=32, GAIN_SHIFT=4, FCW_MIN=1, FCW_MAX=127):
- Reset, then enable=1, no control -> dco_clk period 8 clk, 50% duty; dco_tick every 8 cycles; fcw=32; running=1.
- control=+2 with valid for 1 cycle mid-period -> ctrl_ready drops next cycle; fcw=64 only after the next dco_tick; period then 4; ctrl_ready returns to 1.
- control=+32767 -> fcw=127, sat=1. Then control=-32768 -> fcw=1, sat=1, period 256.
- ctrl_valid held continuously with two different values -> the second is accepted only after the first is applied at a wrap; no word is lost or reordered.
- enable dropped at acc=0x60 -> dco_clk completes its period to the wrap; state IDLE; dco_clk=0; no short pulse; running falls after the wrap.
- rst_n asserted mid-RUN -> all outputs reach reset values asynchronously; after release with enable=1, period is 8 again with fcw=BASE_FCW.
